// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file write-back queue.
// Optional REG_WB_BYPASS_EN adds newest-match forwarding data.
package reg_wb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/reg_wb_match.sv
// Snoops queued writes for one read port and flags a pending hazard.
// Under REG_WB_BYPASS_EN it also returns the newest matching data.
module reg_wb_match
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] ent,
    input  logic [PW-1:0]         head,
    input  logic [ADDR_W_DEF-1:0] ra,
`ifdef REG_WB_BYPASS_EN
    output logic [DATA_W_DEF-1:0] fwd,
`endif
    output logic                  pend
);

    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid && (ent[i].addr == ra)) begin
                pend = 1'b1;
            end
        end
        if (ra == '0) begin
            pend = 1'b0;
        end
    end

`ifdef REG_WB_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk oldest to newest so the last hit is the youngest write.
    always_comb begin
        fwd = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (ent[idx].valid && (ent[idx].addr == ra)) begin
                fwd = ent[idx].data;
            end
        end
        if (!pend) begin
            fwd = '0;
        end
    end
`else
    logic unused_bits;

    always_comb begin
        unused_bits = ^head;
        for (int i = 0; i < DEPTH; i++) begin
            unused_bits = unused_bits ^ (^ent[i].data);
        end
    end
`endif

endmodule

// File: rtl/reg_wb_queue.sv
// Write-side FIFO feeding the 8x8 register file, with read-hazard snooping.
// Define REG_WB_BYPASS_EN to add fwd1_data/fwd2_data forwarding outputs.
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      wb_hold,
    output logic                      regwrite,
    output logic [ADDR_W-1:0]         wa,
    output logic [DATA_W-1:0]         wd,
    input  logic [ADDR_W-1:0]         ra1,
    input  logic [ADDR_W-1:0]         ra2,
    output logic                      pend1,
    output logic                      pend2,
`ifdef REG_WB_BYPASS_EN
    output logic [DATA_W-1:0]         fwd1_data,
    output logic [DATA_W-1:0]         fwd2_data,
`endif
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    wb_entry_t [DEPTH-1:0] q;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         cnt;
    logic                  push;
    logic                  pop;
    logic                  nonempty;

    assign nonempty = (cnt != '0);
    assign in_ready = (cnt != CW'(DEPTH));
    // r0 writes finish the handshake but never occupy a slot.
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign regwrite = nonempty && !wb_hold;
    assign pop      = regwrite;
    assign wa       = nonempty ? q[head].addr : '0;
    assign wd       = nonempty ? q[head].data : '0;
    assign count    = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pop) begin
                q[head].valid <= 1'b0;
                head          <= head + 1'b1;
            end
            if (push) begin
                q[tail] <= '{valid: 1'b1, addr: in_addr, data: in_data};
                tail    <= tail + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    reg_wb_match #(.DEPTH(DEPTH)) u_match1 (
        .ent  (q),
        .head (head),
        .ra   (ra1),
`ifdef REG_WB_BYPASS_EN
        .fwd  (fwd1_data),
`endif
        .pend (pend1)
    );

    reg_wb_match #(.DEPTH(DEPTH)) u_match2 (
        .ent  (q),
        .head (head),
        .ra   (ra2),
`ifdef REG_WB_BYPASS_EN
        .fwd  (fwd2_data),
`endif
        .pend (pend2)
    );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed, table-driven bench for reg_wb_queue.
// Covers REG_WB_BYPASS_EN forwarding when that macro is defined.
module tb_reg_wb_queue;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_addr;
    logic [7:0] in_data;
    logic       wb_hold;
    logic       regwrite;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       pend1;
    logic       pend2;
    logic [2:0] count;
`ifdef REG_WB_BYPASS_EN
    logic [7:0] fwd1_data;
    logic [7:0] fwd2_data;
`endif

    int checks;
    int failures;

    reg_wb_queue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wb_hold  (wb_hold),
        .regwrite (regwrite),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .pend1    (pend1),
        .pend2    (pend2),
`ifdef REG_WB_BYPASS_EN
        .fwd1_data(fwd1_data),
        .fwd2_data(fwd2_data),
`endif
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] a;
        logic [7:0] d;
        logic       h;
        logic [2:0] r1;
        logic [2:0] r2;
        logic       e_rdy;
        logic       e_rw;
        logic [2:0] e_wa;
        logic [7:0] e_wd;
        logic [2:0] e_cnt;
        logic       e_p1;
        logic       e_p2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, input logic [2:0] a, input logic [7:0] d,
        input logic h, input logic [2:0] r1, input logic [2:0] r2,
        input logic e_rdy, input logic e_rw, input logic [2:0] e_wa,
        input logic [7:0] e_wd, input logic [2:0] e_cnt,
        input logic e_p1, input logic e_p2);
        vec_t t;
        t.v = v; t.a = a; t.d = d; t.h = h; t.r1 = r1; t.r2 = r2;
        t.e_rdy = e_rdy; t.e_rw = e_rw; t.e_wa = e_wa; t.e_wd = e_wd;
        t.e_cnt = e_cnt; t.e_p1 = e_p1; t.e_p2 = e_p2;
        return t;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] a,
                         input logic [7:0] d, input logic h);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wb_hold  = h;
    endtask

    function automatic logic [2:0] saddr(input int k);
        return 3'((k % 7) + 1);
    endfunction

    int rw_seen;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        ra1 = 3'd0;
        ra2 = 3'd0;

        // single write to r3
        tbl.push_back(mk(1,3,8'h34,0, 0,0, 1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0, 3,0, 1,1,3,8'h34,1,1,0));
        tbl.push_back(mk(0,0,8'h00,0, 3,0, 1,0,0,8'h00,0,0,0));
        // fill under hold, fifth push refused
        tbl.push_back(mk(1,1,8'h11,1, 4,5, 1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(1,2,8'h22,1, 4,5, 1,0,1,8'h11,1,0,0));
        tbl.push_back(mk(1,3,8'h33,1, 4,5, 1,0,1,8'h11,2,0,0));
        tbl.push_back(mk(1,4,8'h44,1, 4,5, 1,0,1,8'h11,3,0,0));
        tbl.push_back(mk(1,5,8'h55,1, 4,5, 0,0,1,8'h11,4,1,0));
        tbl.push_back(mk(0,0,8'h00,0, 4,5, 0,1,1,8'h11,4,1,0));
        tbl.push_back(mk(0,0,8'h00,0, 4,5, 1,1,2,8'h22,3,1,0));
        tbl.push_back(mk(0,0,8'h00,0, 4,5, 1,1,3,8'h33,2,1,0));
        tbl.push_back(mk(0,0,8'h00,0, 4,5, 1,1,4,8'h44,1,1,0));
        tbl.push_back(mk(0,0,8'h00,0, 4,5, 1,0,0,8'h00,0,0,0));
        // eight back-to-back writes, pointers wrap twice
        for (int k = 0; k <= 8; k++) begin
            tbl.push_back(mk(
                k < 8, (k < 8) ? saddr(k) : 3'd0, (k < 8) ? 8'(8'hA0 + k) : 8'h00, 0,
                (k > 0) ? saddr(k - 1) : 3'd0, (k < 8) ? saddr(k) : 3'd0,
                1, k > 0, (k > 0) ? saddr(k - 1) : 3'd0,
                (k > 0) ? 8'(8'hA0 + k - 1) : 8'h00, (k > 0) ? 3'd1 : 3'd0,
                k > 0, 0));
        end
        tbl.push_back(mk(0,0,8'h00,0, 1,0, 1,0,0,8'h00,0,0,0));
        // r0 discard
        tbl.push_back(mk(1,0,8'hFF,0, 0,0, 1,0,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0, 0,0, 1,0,0,8'h00,0,0,0));

        #2;
        check("rst_regwrite", regwrite, 0);
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 1);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_pend", {pend1, pend2}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].h);
            ra1 = tbl[i].r1;
            ra2 = tbl[i].r2;
            #1;
            check($sformatf("v%0d_ready", i), in_ready, tbl[i].e_rdy);
            check($sformatf("v%0d_regwrite", i), regwrite, tbl[i].e_rw);
            check($sformatf("v%0d_wa", i), wa, tbl[i].e_wa);
            check($sformatf("v%0d_wd", i), wd, tbl[i].e_wd);
            check($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
            check($sformatf("v%0d_pend1", i), pend1, tbl[i].e_p1);
            check($sformatf("v%0d_pend2", i), pend2, tbl[i].e_p2);
        end

        // same-register hazard, newest data forwarded
        @(negedge clk);
        drive(1'b1, 3'd2, 8'h56, 1'b1);
        @(negedge clk);
        drive(1'b1, 3'd2, 8'h23, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 1'b1);
        ra1 = 3'd2;
        ra2 = 3'd5;
        #1;
        check("hz_count", count, 2);
        check("hz_pend1", pend1, 1);
        check("hz_pend2", pend2, 0);
        check("hz_held", regwrite, 0);
`ifdef REG_WB_BYPASS_EN
        check("hz_fwd1", fwd1_data, 8'h23);
        check("hz_fwd2", fwd2_data, 8'h00);
`endif
        @(negedge clk);
        wb_hold = 1'b0;
        #1;
        check("hz_first_rw", regwrite, 1);
        check("hz_first_wd", wd, 8'h56);
        @(negedge clk);
        #1;
        check("hz_second_wd", wd, 8'h23);
        check("hz_second_pend1", pend1, 1);
`ifdef REG_WB_BYPASS_EN
        check("hz_second_fwd1", fwd1_data, 8'h23);
`endif
        @(negedge clk);
        #1;
        check("hz_drained_pend1", pend1, 0);
        check("hz_drained_count", count, 0);

        // async reset with three entries queued
        @(negedge clk);
        drive(1'b1, 3'd1, 8'h61, 1'b1);
        @(negedge clk);
        drive(1'b1, 3'd2, 8'h62, 1'b1);
        @(negedge clk);
        drive(1'b1, 3'd3, 8'h63, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'd0, 8'h00, 1'b0);
        ra1 = 3'd1;
        ra2 = 3'd3;
        #1;
        check("ar_pre_count", count, 3);
        check("ar_pre_rw", regwrite, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_rw", regwrite, 0);
        check("ar_count", count, 0);
        check("ar_pend", {pend1, pend2}, 0);
        check("ar_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rw_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (regwrite) rw_seen++;
        end
        check("ar_no_writes_after", rw_seen, 0);
        check("ar_post_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-side front end for the 8x8 register file.
- Accepts register-write results from the execute stage over a valid/ready handshake and buffers them in a small FIFO.
- Drains one write per cycle into the register file's regwrite/wa/wd inputs.
- Reports per-read-port hazards when a read address matches a write still in flight, so the read side can stall.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width (8 registers).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  execute stage offers a write.
- in_ready  output  1  queue can accept a write.
- in_addr  input  ADDR_W  destination register.
- in_data  input  DATA_W  write data.
- wb_hold  input  1  suppresses draining this cycle.
- regwrite  output  1  write strobe to the register file.
- wa  output  ADDR_W  write address to the register file.
- wd  output  DATA_W  write data to the register file.
- ra1  input  ADDR_W  read address, port 1 (snooped).
- ra2  input  ADDR_W  read address, port 2 (snooped).
- pend1  output  1  write to ra1 is pending.
- pend2  output  1  write to ra2 is pending.
- count  output  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async assert, sync release): count=0, head/tail pointers=0, all entry valid bits=0.
- Outputs during reset: regwrite=0, wa=0, wd=0, pend1=pend2=0, in_ready=1.
- Accept: a push occurs when in_valid && in_ready at a rising edge.
  - in_ready = (count != DEPTH); it does not depend on a same-cycle pop.
- Register 0: writes with in_addr==0 complete the handshake but are discarded. No entry is allocated and count is unchanged.
- Drain: regwrite = (count != 0) && !wb_hold.
  - wa/wd show the head entry whenever count != 0, and 0 when empty.
  - A pop occurs at every edge where regwrite=1; the register file always accepts.
- Latency: an entry accepted at edge N into an empty queue appears on regwrite/wa/wd in the cycle after edge N. Minimum latency is 1 cycle.
- Ordering: strict FIFO. Two queued writes to the same register retire in arrival order.
- Simultaneous push and pop: both take effect and count is unchanged. This is legal whenever count < DEPTH.
- Full: in_ready=0 and in_valid is ignored. A pop while full raises in_ready in the next cycle.
- Pointer wrap-around: modulo DEPTH, with no bubble at the wrap point.
- Hazard flags (combinational from registered state):
  - pend1 = (ra1 != 0) && any valid entry has addr==ra1. pend2 is identical using ra2.
  - The head entry counts as pending in the cycle it is written.
  - A push in the current cycle is not visible until the next cycle.
- wb_hold: freezes draining only. Pushes continue and count can reach DEPTH.
- Reset mid-operation: all queued writes are dropped and none are issued.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- When defined, adds two outputs: fwd1_data and fwd2_data, each DATA_W wide.
  - Each carries the data of the newest valid entry matching its read address. Priority is searched from tail toward head.
  - Each output is 0 when its matching pend flag is 0.
  - The read side uses these for forwarding instead of stalling.
- When undefined: the ports are absent, and no priority mux is built.

Decomposition:
- Package reg_wb_pkg:
  - DATA_W and ADDR_W defaults.
  - wb_entry_t typedef holding valid, addr and data.
  - Function for the count width.
- Sub-module reg_wb_match:
  - Inputs: the entry array, head pointer and one read address.
  - Outputs: pend, plus the newest-match data under REG_WB_BYPASS_EN.
  - Instantiated twice, once per read port.

Test Plan:
- Reset then single write: push (addr 3, data 0x34) at edge 1 -> regwrite=1, wa=3, wd=0x34 for exactly one cycle after edge 1; count returns to 0.
- Fill under hold: wb_hold=1, push 0x11/0x22/0x33/0x44 to regs 1-4 -> count=4, in_ready=0, a 5th push is ignored. Release hold -> four writes in order on consecutive cycles, and in_ready=1 the cycle after the first pop.
- Simultaneous push/pop: stream 8 back-to-back writes with no hold -> count stays at 1 and one write per cycle is issued. Pointers wrap twice with no lost or duplicated data.
- Register 0 discard: push addr 0, data 0xFF -> in_ready stays 1, count stays 0, no regwrite; with ra1=0, pend1=0.
- Hazard:
  - Setup: hold=1, queue (r2, 0x56) then (r2, 0x23).
  - ra1=2, ra2=5 -> pend1=1, pend2=0.
  - With REG_WB_BYPASS_EN, fwd1_data=0x23 (newest entry).
  - After both drain -> pend1=0.
- Async reset mid-stream: assert rst_n=0 with 3 entries queued, between edges -> regwrite, count and pend drop to 0 immediately; no writes are issued after release.
